mux_nx1_pipe: RTL and testbench

Parametrised, registered N-to-1 multiplexer of W-bit channels with a valid/ready output handshake. It generalises the combinational 8x1 bit mux in two ways: arbitrary channel count and width, and a scan mode that walks all channels round-robin using an internal pointer. It sits between a bank of parallel sources and a single serial consumer, such as a debug/status serialiser or a sample collector.

---
 rtl/mux_nx1_pipe_if.sv | 30 +++
 rtl/mux_nx1_pipe.sv | 93 +++++++++
 tb/tb_mux_nx1_pipe.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mux_nx1_pipe_if.sv
// Source-side and consumer-side signals of the registered N-to-1 channel mux.
// The master modport drives the channels and requests. The slave modport is the mux itself.
interface mux_nx1_pipe_if #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 1
);
    localparam int unsigned SW = $clog2(N);

    logic [N*W-1:0] i;
    logic [SW-1:0]  s;
    logic           mode;
    logic           scan_clr;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   y;
    logic [SW-1:0]  y_sel;
    logic           y_err;
    logic           y_valid;
    logic           y_ready;

    modport master (
        output i, s, mode, scan_clr, in_valid, y_ready,
        input  in_ready, y, y_sel, y_err, y_valid
    );

    modport slave (
        input  i, s, mode, scan_clr, in_valid, y_ready,
        output in_ready, y, y_sel, y_err, y_valid
    );
endinterface

// File: rtl/mux_nx1_pipe.sv
// Registered N-to-1 mux of W-bit channels with a valid/ready output stage.
// Channels are chosen by a direct select or by a round-robin scan pointer.
module mux_nx1_pipe #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 1
) (
    input logic           clk,
    input logic           rst_n,
    mux_nx1_pipe_if.slave bus
);
    localparam int unsigned   SW      = $clog2(N);
    localparam logic [SW:0]   NumCh   = (SW+1)'(N);
    localparam logic [SW-1:0] LastIdx = SW'(N - 1);

    logic [W-1:0]  r_y,     w_y_d;
    logic [SW-1:0] r_y_sel, w_y_sel_d;
    logic          r_y_err, w_y_err_d;
    logic          r_valid, w_valid_d;
    logic [SW-1:0] r_ptr,   w_ptr_d;

    logic          w_accept;
    logic          w_s_ok;
    logic          w_err;
    logic [SW-1:0] w_p;
    logic [SW-1:0] w_p_inc;
    logic [SW-1:0] w_idx;
    logic [W-1:0]  w_ch;

    assign bus.in_ready = !r_valid || bus.y_ready;
    assign w_accept     = bus.in_valid && bus.in_ready;

    // A clear in the accept cycle makes this sample come from channel 0.
    assign w_p     = bus.scan_clr ? '0 : r_ptr;
    assign w_p_inc = (w_p == LastIdx) ? '0 : w_p + 1'b1;
    assign w_s_ok  = ({1'b0, bus.s} < NumCh);
    assign w_idx   = bus.mode ? w_p : bus.s;
    assign w_err   = !bus.mode && !w_s_ok;

    // An out-of-range select matches no channel, so the data falls back to zero.
    always_comb begin
        w_ch = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (w_idx == SW'(k)) begin
                w_ch = bus.i[k*W +: W];
            end
        end
    end

    always_comb begin
        w_y_d     = r_y;
        w_y_sel_d = r_y_sel;
        w_y_err_d = r_y_err;
        w_valid_d = r_valid;
        w_ptr_d   = r_ptr;
        if (w_accept) begin
            w_y_d     = w_ch;
            w_y_sel_d = w_idx;
            w_y_err_d = w_err;
            w_valid_d = 1'b1;
            if (bus.mode) begin
                w_ptr_d = w_p_inc;
            end
        end else begin
            if (r_valid && bus.y_ready) begin
                w_valid_d = 1'b0;
            end
            if (bus.scan_clr) begin
                w_ptr_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y     <= '0;
            r_y_sel <= '0;
            r_y_err <= 1'b0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
        end else begin
            r_y     <= w_y_d;
            r_y_sel <= w_y_sel_d;
            r_y_err <= w_y_err_d;
            r_valid <= w_valid_d;
            r_ptr   <= w_ptr_d;
        end
    end

    assign bus.y       = r_y;
    assign bus.y_sel   = r_y_sel;
    assign bus.y_err   = r_y_err;
    assign bus.y_valid = r_valid;
endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Directed bench for mux_nx1_pipe: an 8x1-bit instance and a 5x4-bit instance
// share clock and reset, and every expected value is hand-computed.
module tb_mux_nx1_pipe;
    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    int exp_scan_y [10] = '{1, 0, 0, 0, 0, 1, 0, 1, 1, 0};
    int exp_scan_s [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    int exp_b_y    [6]  = '{'hA, 'hB, 'hC, 'hD, 'hE, 'hA};
    int exp_b_s    [6]  = '{0, 1, 2, 3, 4, 0};

    mux_nx1_pipe_if #(.N(8), .W(1)) ifa ();
    mux_nx1_pipe_if #(.N(5), .W(4)) ifb ();

    mux_nx1_pipe #(.N(8), .W(1)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    mux_nx1_pipe #(.N(5), .W(4)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        ifa.i = '0; ifa.s = '0; ifa.mode = 1'b0; ifa.scan_clr = 1'b0;
        ifa.in_valid = 1'b0; ifa.y_ready = 1'b0;
        ifb.i = '0; ifb.s = '0; ifb.mode = 1'b0; ifb.scan_clr = 1'b0;
        ifb.in_valid = 1'b0; ifb.y_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check_eq("rst_y",       ifa.y,        0);
        check_eq("rst_y_sel",   ifa.y_sel,    0);
        check_eq("rst_y_err",   ifa.y_err,    0);
        check_eq("rst_y_valid", ifa.y_valid,  0);
        check_eq("rst_in_rdy",  ifa.in_ready, 1);
        check_eq("rst_b_valid", ifb.y_valid,  0);
        rst_n = 1'b1;
        tick();

        // Direct select, channel 3 of 8'b11001100
        ifa.i = 8'b11001100; ifa.s = 3'd3; ifa.mode = 1'b0;
        ifa.in_valid = 1'b1; ifa.y_ready = 1'b1;
        tick();
        check_eq("dir_y",       ifa.y,       1);
        check_eq("dir_y_sel",   ifa.y_sel,   3);
        check_eq("dir_y_err",   ifa.y_err,   0);
        check_eq("dir_y_valid", ifa.y_valid, 1);
        ifa.in_valid = 1'b0;
        tick();
        check_eq("dir_drain", ifa.y_valid, 0);

        // Scan with wrap 7 -> 0
        ifa.i = 8'b10100001; ifa.mode = 1'b1; ifa.in_valid = 1'b1; ifa.y_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_eq("scan_y",     ifa.y,       exp_scan_y[k]);
            check_eq("scan_y_sel", ifa.y_sel,   exp_scan_s[k]);
            check_eq("scan_valid", ifa.y_valid, 1);
        end

        // Clear pointer with no accept, then one accept under backpressure
        ifa.in_valid = 1'b0; ifa.scan_clr = 1'b1;
        tick();
        ifa.scan_clr = 1'b0;
        check_eq("clr_drain", ifa.y_valid, 0);
        ifa.in_valid = 1'b1; ifa.y_ready = 1'b0;
        tick();
        check_eq("bp_first_sel",   ifa.y_sel,   0);
        check_eq("bp_first_valid", ifa.y_valid, 1);
        ifa.i = 8'b01011110; ifa.mode = 1'b0; ifa.s = 3'd5;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq("bp_in_ready", ifa.in_ready, 0);
            tick();
            check_eq("bp_hold_y",     ifa.y,       1);
            check_eq("bp_hold_sel",   ifa.y_sel,   0);
            check_eq("bp_hold_valid", ifa.y_valid, 1);
        end
        ifa.i = 8'b10100001; ifa.mode = 1'b1; ifa.y_ready = 1'b1;
        #1;
        check_eq("bp_release_rdy", ifa.in_ready, 1);
        tick();
        check_eq("bp_resume_sel1", ifa.y_sel,   1);
        check_eq("bp_resume_y1",   ifa.y,       0);
        tick();
        check_eq("bp_resume_sel2", ifa.y_sel,   2);
        check_eq("bp_resume_val2", ifa.y_valid, 1);
        tick();
        tick();
        check_eq("pre_clr_sel", ifa.y_sel, 4);

        // Clear together with an accept at pointer 5
        ifa.scan_clr = 1'b1;
        tick();
        ifa.scan_clr = 1'b0;
        check_eq("clr_acc_sel", ifa.y_sel, 0);
        check_eq("clr_acc_y",   ifa.y,     1);
        tick();
        check_eq("clr_acc_next", ifa.y_sel, 1);
        tick();
        check_eq("to_ptr3_sel", ifa.y_sel, 2);

        // Clear alone at pointer 3
        ifa.in_valid = 1'b0; ifa.scan_clr = 1'b1;
        tick();
        ifa.scan_clr = 1'b0; ifa.in_valid = 1'b1;
        tick();
        check_eq("clr_only_sel", ifa.y_sel, 0);

        // Reach pointer 6 with a held sample, then reset asynchronously
        for (int k = 0; k < 5; k++) tick();
        check_eq("pre_rst_sel", ifa.y_sel, 5);
        check_eq("pre_rst_y",   ifa.y,     1);
        ifa.in_valid = 1'b0; ifa.y_ready = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_y",     ifa.y,       0);
        check_eq("async_rst_sel",   ifa.y_sel,   0);
        check_eq("async_rst_err",   ifa.y_err,   0);
        check_eq("async_rst_valid", ifa.y_valid, 0);
        #3;
        rst_n = 1'b1;
        ifa.in_valid = 1'b1; ifa.y_ready = 1'b1; ifa.mode = 1'b1;
        tick();
        check_eq("post_rst_sel",   ifa.y_sel,   0);
        check_eq("post_rst_valid", ifa.y_valid, 1);
        ifa.in_valid = 1'b0;

        // N=5, W=4: out-of-range direct select, then valid select
        ifb.i = 20'hEDCBA; ifb.mode = 1'b0; ifb.s = 3'd6;
        ifb.in_valid = 1'b1; ifb.y_ready = 1'b1;
        tick();
        check_eq("b_oor_y",     ifb.y,       0);
        check_eq("b_oor_sel",   ifb.y_sel,   6);
        check_eq("b_oor_err",   ifb.y_err,   1);
        check_eq("b_oor_valid", ifb.y_valid, 1);
        ifb.s = 3'd4;
        tick();
        check_eq("b_dir_y",   ifb.y,     'hE);
        check_eq("b_dir_sel", ifb.y_sel, 4);
        check_eq("b_dir_err", ifb.y_err, 0);

        // N=5 scan wraps 4 -> 0
        ifb.mode = 1'b1; ifb.s = 3'd7;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_eq("b_scan_y",   ifb.y,     exp_b_y[k]);
            check_eq("b_scan_sel", ifb.y_sel, exp_b_s[k]);
            check_eq("b_scan_err", ifb.y_err, 0);
        end
        ifb.in_valid = 1'b0;
        tick();
        check_eq("b_drain", ifb.y_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
